// File: rtl/nexusv_lsu.sv
// Load/store unit: turns one core access into a valid/ready word-bus transaction
// and returns an extended load result or an error flag.
module nexusv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // Counter runs 0..TIMEOUT_CYCLES-1; the abort fires in the cycle it holds the last value.
  localparam int              CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);

  logic [1:0]    state, state_nxt;
  logic          we_q;
  logic [2:0]    funct3_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [CW-1:0] tmo_cnt;

  logic          req_illegal;
  logic          req_misaligned;
  logic          req_bad;
  logic          handshake;
  logic          tmo_hit;
  logic [31:0]   lane;
  logic [31:0]   load_data;
  logic [3:0]    store_strb;
  logic [31:0]   store_data;

  // Decode legality of the incoming request while still in IDLE.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    if (req_we)
      req_illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    else
      req_illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    case (req_funct3[1:0])
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase
  end

  assign req_bad   = req_illegal || req_misaligned;
  assign handshake = (state == REQ) && bus_ready;
  assign tmo_hit   = TMO_EN && (tmo_cnt == TMO_LAST);

  // Byte lane selected by the low address bits, then extended per funct3.
  always_comb begin
    lane      = bus_rdata >> {addr_q[1:0], 3'b000};
    load_data = lane;
    case (funct3_q)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'd0, lane[7:0]};
      3'b101:  load_data = {16'd0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  // Stores replicate the datum across lanes; the strobe picks the real target bytes.
  always_comb begin
    store_strb = 4'b1111;
    store_data = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        store_strb = 4'b0001 << addr_q[1:0];
        store_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        store_strb = 4'b0011 << addr_q[1:0];
        store_data = {2{wdata_q[15:0]}};
      end
      default: begin
        store_strb = 4'b1111;
        store_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = req_bad ? RESP : REQ;
      REQ: begin
        if (handshake)    state_nxt = we_q ? RESP : WAIT_R;
        else if (tmo_hit) state_nxt = RESP;
      end
      WAIT_R:  if (bus_rvalid || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            err_q    <= req_bad;
            rdata_q  <= 32'd0;
            tmo_cnt  <= '0;
          end
        end
        REQ: begin
          if (handshake) begin
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit) err_q <= 1'b1;
          end
        end
        WAIT_R: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (bus_rvalid)   rdata_q <= load_data;
          else if (tmo_hit) err_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are gated by state so everything outside an active phase reads as zero.
  assign req_ready = (state == IDLE);
  assign bus_valid = (state == REQ);
  assign bus_we    = bus_valid && we_q;
  assign bus_addr  = bus_valid ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus_wstrb = bus_we ? store_strb : 4'b0000;
  assign bus_wdata = bus_we ? store_data : 32'd0;
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
  assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_nexusv_lsu.sv
// Directed bench for nexusv_lsu: stores, loads, errors, stalls, timeouts and mid-access reset.
module tb_nexusv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  nexusv_lsu #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wstrb  (bus_wstrb),
    .bus_wdata  (bus_wdata),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    tick();
    req_valid  = 1'b0;
  endtask

  // Load with zero-wait handshake; a decoy rvalid rides along with the handshake cycle.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] word_addr, input logic [31:0] word,
                         input logic [31:0] exp);
    bus_ready  = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata  = ~word;
    issue(1'b0, f3, addr, 32'd0);
    check({tag, "_bus_valid"}, bus_valid, 1'b1);
    check({tag, "_bus_addr"},  bus_addr,  word_addr);
    check({tag, "_wstrb"},     bus_wstrb, 4'b0000);
    tick();
    bus_rdata = word;
    check({tag, "_no_early_rsp"}, rsp_valid, 1'b0);
    tick();
    bus_rvalid = 1'b0;
    check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    check({tag, "_rdata"},     rsp_rdata, exp);
    check({tag, "_err"},       rsp_err,   1'b0);
    tick();
    check({tag, "_rsp_drop"},  rsp_valid, 1'b0);
  endtask

  // Access rejected on accept: response next cycle with err, never any bus request.
  task automatic do_reject(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr);
    bus_ready = 1'b1;
    issue(we, f3, addr, 32'hFFFF_FFFF);
    check({tag, "_no_bus"},    bus_valid, 1'b0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    check({tag, "_err"},       rsp_err,   1'b1);
    check({tag, "_rdata"},     rsp_rdata, 32'd0);
    tick();
    check({tag, "_no_bus2"},   bus_valid, 1'b0);
    check({tag, "_idle"},      req_ready, 1'b1);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 32'd0;
    tick();
    tick();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_bus_valid", bus_valid, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_bus_wstrb", bus_wstrb, 4'b0000);
    check("rst_bus_addr",  bus_addr,  32'd0);
    rst = 1'b0;
    tick();

    // SB to byte 3: strobe on the top lane, byte replicated, response two cycles after accept.
    bus_ready = 1'b1;
    issue(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5);
    check("sb_bus_valid", bus_valid, 1'b1);
    check("sb_bus_we",    bus_we,    1'b1);
    check("sb_bus_addr",  bus_addr,  32'h0000_0100);
    check("sb_wstrb",     bus_wstrb, 4'b1000);
    check("sb_wdata",     bus_wdata, 32'hA5A5_A5A5);
    check("sb_ready_low", req_ready, 1'b0);
    check("sb_no_rsp",    rsp_valid, 1'b0);
    tick();
    check("sb_rsp_valid", rsp_valid, 1'b1);
    check("sb_rsp_err",   rsp_err,   1'b0);
    check("sb_rsp_rdata", rsp_rdata, 32'd0);
    check("sb_bus_drop",  bus_valid, 1'b0);
    tick();
    check("sb_rsp_drop",  rsp_valid, 1'b0);
    check("sb_idle",      req_ready, 1'b1);

    // Loads: lane select and sign/zero extension.
    do_load("lb",  3'b000, 32'h0000_0201, 32'h0000_0200, 32'h0000_F000, 32'hFFFF_FFF0);
    do_load("lbu", 3'b100, 32'h0000_0201, 32'h0000_0200, 32'h0000_F000, 32'h0000_00F0);
    do_load("lh",  3'b001, 32'h0000_0202, 32'h0000_0200, 32'h8001_0000, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h0000_0202, 32'h0000_0200, 32'h8001_0000, 32'h0000_8001);
    do_load("lw",  3'b010, 32'h0000_0300, 32'h0000_0300, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Misaligned and illegal accesses.
    do_reject("lw_mis",    1'b0, 3'b010, 32'h0000_0302);
    do_reject("lh_mis",    1'b0, 3'b001, 32'h0000_0201);
    do_reject("st_f3_011", 1'b1, 3'b011, 32'h0000_0000);
    do_reject("ld_f3_110", 1'b0, 3'b110, 32'h0000_0000);
    do_reject("sbu_f3",    1'b1, 3'b100, 32'h0000_0000);

    // SH held off by bus_ready for 5 cycles; request fields must not move.
    bus_ready = 1'b0;
    issue(1'b1, 3'b001, 32'h0000_0402, 32'h1234_BEEF);
    for (int i = 0; i < 5; i++) begin
      check("sh_stall_valid", bus_valid, 1'b1);
      check("sh_stall_addr",  bus_addr,  32'h0000_0400);
      check("sh_stall_wstrb", bus_wstrb, 4'b1100);
      check("sh_stall_wdata", bus_wdata, 32'hBEEF_BEEF);
      check("sh_stall_norsp", rsp_valid, 1'b0);
      tick();
    end
    bus_ready = 1'b1;
    check("sh_hs_valid", bus_valid, 1'b1);
    check("sh_hs_wstrb", bus_wstrb, 4'b1100);
    tick();
    check("sh_rsp_valid", rsp_valid, 1'b1);
    check("sh_rsp_err",   rsp_err,   1'b0);
    tick();
    check("sh_rsp_drop",  rsp_valid, 1'b0);

    // Load whose data never arrives: abort after 8 cycles in WAIT_R.
    bus_ready  = 1'b1;
    bus_rvalid = 1'b0;
    issue(1'b0, 3'b010, 32'h0000_0500, 32'd0);
    check("tmo_r_bus_valid", bus_valid, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("tmo_r_wait_norsp", rsp_valid, 1'b0);
      check("tmo_r_wait_nobus", bus_valid, 1'b0);
      tick();
    end
    check("tmo_r_rsp_valid", rsp_valid, 1'b1);
    check("tmo_r_rsp_err",   rsp_err,   1'b1);
    check("tmo_r_rsp_rdata", rsp_rdata, 32'd0);
    tick();
    check("tmo_r_rsp_drop",  rsp_valid, 1'b0);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hFFFF_FFFF;
    tick();
    check("stray_rv_norsp", rsp_valid, 1'b0);
    check("stray_rv_idle",  req_ready, 1'b1);
    tick();
    check("stray_rv_norsp2", rsp_valid, 1'b0);
    bus_rvalid = 1'b0;

    // Store never accepted by the bus: abort after 8 cycles in REQ, bus_valid dropped.
    bus_ready = 1'b0;
    issue(1'b1, 3'b010, 32'h0000_0700, 32'h5555_AAAA);
    for (int i = 0; i < 8; i++) begin
      check("tmo_q_valid", bus_valid, 1'b1);
      check("tmo_q_norsp", rsp_valid, 1'b0);
      tick();
    end
    check("tmo_q_rsp_valid", rsp_valid, 1'b1);
    check("tmo_q_rsp_err",   rsp_err,   1'b1);
    check("tmo_q_bus_drop",  bus_valid, 1'b0);
    tick();
    check("tmo_q_rsp_drop",  rsp_valid, 1'b0);

    // Reset while waiting for read data, then a late rvalid, then a normal access.
    bus_ready  = 1'b1;
    bus_rvalid = 1'b0;
    issue(1'b0, 3'b010, 32'h0000_0600, 32'd0);
    tick();
    tick();
    check("rstw_waiting", rsp_valid, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_req_ready", req_ready, 1'b1);
    check("rstw_bus_valid", bus_valid, 1'b0);
    check("rstw_rsp_valid", rsp_valid, 1'b0);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h0000_0011;
    tick();
    bus_rvalid = 1'b0;
    check("rstw_late_rv_norsp", rsp_valid, 1'b0);
    check("rstw_late_rv_idle",  req_ready, 1'b1);
    do_load("post_rst_lw", 3'b010, 32'h0000_0604, 32'h0000_0604, 32'h1357_9BDF, 32'h1357_9BDF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
